io_pad_bank_ctrl: RTL and testbench

- Parametrised N-channel controller sitting in front of an array of bidirectional 1.2 V IO pads.
- Owns each pad's drive strength, pull-up/pull-down and output-enable control pins.
- Inserts a break-before-make turnaround on every direction change.
- Synchronises and glitch-filters each pad's Schmitt readback, and flags clean edges to core logic.

---
 rtl/io_pad_pkg.sv | 24 ++
 rtl/io_pad_chan.sv | 126 ++++++++++++
 rtl/io_pad_bank_ctrl.sv | 53 +++++
 tb/tb_io_pad_bank_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pad_pkg.sv
// Shared types, reset values and counter-width helpers for the IO pad bank controller.
package io_pad_pkg;

    typedef enum logic [1:0] {
        IN       = 2'b00,
        TURN_OUT = 2'b01,
        OUT      = 2'b10,
        TURN_IN  = 2'b11
    } chan_state_t;

    localparam logic RST_PEN = 1'b1;
    localparam logic RST_UD  = 1'b0;
    localparam logic RST_DS  = 1'b0;

    // Turnaround counter only needs to reach TURN_CYC-1; keep at least one bit.
    function automatic int tcnt_w(input int turn_cyc);
        return (turn_cyc > 1) ? $clog2(turn_cyc) : 1;
    endfunction

    function automatic int fcnt_w(input int filt_cyc);
        return (filt_cyc > 0) ? $clog2(filt_cyc + 1) : 1;
    endfunction

endpackage

// File: rtl/io_pad_chan.sv
// One pad channel: break-before-make direction FSM, pin control flops,
// two-flop readback synchroniser and consecutive-cycle glitch filter.
module io_pad_chan
    import io_pad_pkg::*;
#(
    parameter int TURN_CYC = 2,
    parameter int FILT_CYC = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic dir_req,
    input  logic dout,
    input  logic ds_cfg,
    input  logic pen_cfg,
    input  logic ud_cfg,
    input  logic pad_z,
    output logic pad_a,
    output logic pad_out_en,
    output logic pad_ds,
    output logic pad_pen,
    output logic pad_ud,
    output logic din,
    output logic rise,
    output logic fall,
    output logic dir_ack
);

    localparam int TW = tcnt_w(TURN_CYC);
    localparam int FW = fcnt_w(FILT_CYC);
    localparam logic [TW-1:0] T_LAST = (TURN_CYC > 0) ? TW'(TURN_CYC - 1) : '0;
    localparam logic [FW-1:0] F_LAST = (FILT_CYC > 0) ? FW'(FILT_CYC - 1) : '0;

    chan_state_t   state;
    chan_state_t   state_nxt;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_nxt;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        unique case (state)
            IN: begin
                if (dir_req) begin
                    tcnt_nxt = '0;
                    if (TURN_CYC == 0) state_nxt = OUT;
                    else               state_nxt = TURN_OUT;
                end
            end
            TURN_OUT: begin
                if (!dir_req)            state_nxt = IN;
                else if (tcnt == T_LAST) state_nxt = OUT;
                else                     tcnt_nxt  = tcnt + 1'b1;
            end
            OUT: begin
                if (!dir_req) begin
                    tcnt_nxt = '0;
                    if (TURN_CYC == 0) state_nxt = IN;
                    else               state_nxt = TURN_IN;
                end
            end
            TURN_IN: begin
                // Release always runs to completion; dir_req is ignored here.
                if (tcnt == T_LAST) state_nxt = IN;
                else                tcnt_nxt  = tcnt + 1'b1;
            end
            default: state_nxt = IN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IN;
            tcnt       <= '0;
            pad_out_en <= 1'b0;
            dir_ack    <= 1'b0;
            pad_a      <= 1'b0;
            pad_ds     <= RST_DS;
            pad_pen    <= RST_PEN;
            pad_ud     <= RST_UD;
        end else begin
            state      <= state_nxt;
            tcnt       <= tcnt_nxt;
            // OE and the pull are both keyed off next-state so the pull hands over in the same cycle.
            pad_out_en <= (state_nxt == OUT);
            dir_ack    <= (state_nxt == OUT);
            pad_pen    <= pen_cfg & (state_nxt != OUT);
            pad_a      <= dout;
            pad_ds     <= ds_cfg;
            pad_ud     <= ud_cfg;
        end
    end

    logic          s1;
    logic          s2;
    logic [FW-1:0] fcnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            fcnt <= '0;
            din  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= pad_z;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (s2 == din) begin
                fcnt <= '0;
            end else if (fcnt == F_LAST) begin
                // With FILT_CYC=0 fcnt never leaves 0, so this degenerates to din <= s2.
                din  <= s2;
                fcnt <= '0;
                rise <= s2;
                fall <= ~s2;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_pad_bank_ctrl.sv
// N-channel IO pad bank controller: replicates one independent io_pad_chan per pad.
module io_pad_bank_ctrl
    import io_pad_pkg::*;
#(
    parameter int N_CH     = 8,
    parameter int TURN_CYC = 2,
    parameter int FILT_CYC = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N_CH-1:0] dir_req,
    input  logic [N_CH-1:0] dout,
    input  logic [N_CH-1:0] ds_cfg,
    input  logic [N_CH-1:0] pen_cfg,
    input  logic [N_CH-1:0] ud_cfg,
    output logic [N_CH-1:0] pad_a,
    output logic [N_CH-1:0] pad_out_en,
    output logic [N_CH-1:0] pad_ds,
    output logic [N_CH-1:0] pad_pen,
    output logic [N_CH-1:0] pad_ud,
    input  logic [N_CH-1:0] pad_z,
    output logic [N_CH-1:0] din,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] dir_ack
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        io_pad_chan #(
            .TURN_CYC (TURN_CYC),
            .FILT_CYC (FILT_CYC)
        ) u_chan (
            .clk        (clk),
            .rstn       (rstn),
            .dir_req    (dir_req[i]),
            .dout       (dout[i]),
            .ds_cfg     (ds_cfg[i]),
            .pen_cfg    (pen_cfg[i]),
            .ud_cfg     (ud_cfg[i]),
            .pad_z      (pad_z[i]),
            .pad_a      (pad_a[i]),
            .pad_out_en (pad_out_en[i]),
            .pad_ds     (pad_ds[i]),
            .pad_pen    (pad_pen[i]),
            .pad_ud     (pad_ud[i]),
            .din        (din[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .dir_ack    (dir_ack[i])
        );
    end

endmodule

// File: tb/tb_io_pad_bank_ctrl.sv
// Randomised and directed bench for io_pad_bank_ctrl against a countdown/history reference model.
module tb_io_pad_bank_ctrl;

    localparam int N_CH     = 8;
    localparam int TURN_CYC = 3;
    localparam int FILT_CYC = 4;
    localparam int HD       = FILT_CYC + 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N_CH-1:0] dir_req, dout, ds_cfg, pen_cfg, ud_cfg, pad_z;
    logic [N_CH-1:0] pad_a, pad_out_en, pad_ds, pad_pen, pad_ud;
    logic [N_CH-1:0] din, rise, fall, dir_ack;

    io_pad_bank_ctrl #(
        .N_CH     (N_CH),
        .TURN_CYC (TURN_CYC),
        .FILT_CYC (FILT_CYC)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .dir_req    (dir_req),
        .dout       (dout),
        .ds_cfg     (ds_cfg),
        .pen_cfg    (pen_cfg),
        .ud_cfg     (ud_cfg),
        .pad_a      (pad_a),
        .pad_out_en (pad_out_en),
        .pad_ds     (pad_ds),
        .pad_pen    (pad_pen),
        .pad_ud     (pad_ud),
        .pad_z      (pad_z),
        .din        (din),
        .rise       (rise),
        .fall       (fall),
        .dir_ack    (dir_ack)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a channel is either driving or not, optionally with a
    // turnaround countdown toward a target direction.
    bit m_drv  [N_CH];
    bit m_head [N_CH];
    int m_rem  [N_CH];
    bit m_din  [N_CH];
    bit hist   [N_CH][HD];   // pre-edge pad_z samples, index 0 = newest

    logic [N_CH-1:0] e_oe, e_pen, e_a, e_ds, e_ud, e_din, e_rise, e_fall;

    task automatic check(input string tag, input logic [N_CH-1:0] got,
                         input logic [N_CH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_drv[c]  = 1'b0;
            m_head[c] = 1'b0;
            m_rem[c]  = 0;
            m_din[c]  = 1'b0;
            for (int k = 0; k < HD; k++) hist[c][k] = 1'b0;
        end
        e_oe   = '0;
        e_pen  = '1;
        e_a    = '0;
        e_ds   = '0;
        e_ud   = '0;
        e_din  = '0;
        e_rise = '0;
        e_fall = '0;
    endtask

    task automatic model_step();
        for (int c = 0; c < N_CH; c++) begin
            bit req;
            bit flip;
            req = dir_req[c];
            if (m_rem[c] > 0) begin
                if (m_head[c] && !req)  m_rem[c] = 0;
                else if (m_rem[c] == 1) begin
                    m_rem[c] = 0;
                    m_drv[c] = m_head[c];
                end else                m_rem[c]--;
            end else if (m_drv[c] != req) begin
                if (TURN_CYC == 0) m_drv[c] = req;
                else begin
                    m_head[c] = req;
                    m_rem[c]  = TURN_CYC;
                    m_drv[c]  = 1'b0;
                end
            end
            e_oe[c]  = m_drv[c];
            e_pen[c] = pen_cfg[c] & ~m_drv[c];
            e_a[c]   = dout[c];
            e_ds[c]  = ds_cfg[c];
            e_ud[c]  = ud_cfg[c];

            // The synced value seen at this edge is pad_z from two edges back;
            // din flips once FILT_CYC consecutive synced samples disagree with it.
            for (int k = HD - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = pad_z[c];
            flip = 1'b1;
            for (int k = 2; k < FILT_CYC + 2; k++)
                if (hist[c][k] == m_din[c]) flip = 1'b0;
            if (FILT_CYC == 0) flip = (hist[c][2] != m_din[c]);
            e_rise[c] = 1'b0;
            e_fall[c] = 1'b0;
            if (flip) begin
                m_din[c]  = ~m_din[c];
                e_rise[c] = m_din[c];
                e_fall[c] = ~m_din[c];
            end
            e_din[c] = m_din[c];
        end
    endtask

    task automatic compare_all();
        check("oe",   pad_out_en, e_oe);
        check("ack",  dir_ack,    e_oe);
        check("pen",  pad_pen,    e_pen);
        check("a",    pad_a,      e_a);
        check("ds",   pad_ds,     e_ds);
        check("ud",   pad_ud,     e_ud);
        check("din",  din,        e_din);
        check("rise", rise,       e_rise);
        check("fall", fall,       e_fall);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rstn) model_reset();
        else       model_step();
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rstn    = 1'b0;
        dir_req = '0;
        dout    = '0;
        ds_cfg  = '0;
        pen_cfg = '1;
        ud_cfg  = '0;
        pad_z   = '0;
        model_reset();

        // Reset values, then idle hold after release.
        ticks(3);
        rstn = 1'b1;
        ticks(5);
        check("idle_pen", pad_pen, 8'hFF);

        // Turnaround on channel 0: OE after TURN_CYC+1 edges, pull released together.
        dir_req = 8'h01;
        ticks(3);
        check("turn_oe_early", pad_out_en, 8'h00);
        tick();
        check("turn_oe",  pad_out_en, 8'h01);
        check("turn_ack", dir_ack,    8'h01);
        check("turn_pen", pad_pen,    8'hFE);
        ticks(5);
        dir_req = 8'h00;
        tick();
        check("drop_oe",  pad_out_en, 8'h00);
        check("drop_pen", pad_pen,    8'hFF);
        ticks(3);
        dir_req = 8'h01;
        ticks(4);
        check("reissue_oe", pad_out_en, 8'h01);
        dir_req = 8'h00;
        ticks(4);

        // Abort on channel 1 during TURN_OUT.
        dir_req = 8'h02;
        ticks(2);
        dir_req = 8'h00;
        ticks(6);
        check("abort_oe", pad_out_en, 8'h00);

        // Glitch of 3 cycles on channel 2 is rejected.
        pad_z = 8'h04;
        ticks(3);
        pad_z = 8'h00;
        ticks(8);
        check("glitch_din", din, 8'h00);

        // Clean rising then falling edge on channel 2.
        pad_z = 8'h04;
        ticks(5);
        check("edge_din_early", din, 8'h00);
        tick();
        check("edge_din",  din,  8'h04);
        check("edge_rise", rise, 8'h04);
        tick();
        check("edge_rise_end", rise, 8'h00);
        pad_z = 8'h00;
        ticks(5);
        tick();
        check("edge_fall",     fall, 8'h04);
        check("edge_din_fall", din,  8'h00);

        // Randomised traffic on all channels.
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 9) == 0) dir_req[c] = ~dir_req[c];
                if ($urandom_range(0, 3) == 0) pad_z[c]   = ~pad_z[c];
            end
            dout    = N_CH'($urandom);
            ds_cfg  = N_CH'($urandom);
            pen_cfg = N_CH'($urandom);
            ud_cfg  = N_CH'($urandom);
            tick();
        end

        // Asynchronous reset while every channel is driving.
        dir_req = '1;
        ticks(12);
        check("all_out", pad_out_en, 8'hFF);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check("async_oe",  pad_out_en, 8'h00);
        check("async_ack", dir_ack,    8'h00);
        check("async_pen", pad_pen,    8'hFF);
        check("async_din", din,        8'h00);
        dir_req = '0;
        tick();
        #2;
        rstn = 1'b1;
        ticks(2);
        dir_req = 8'h08;
        ticks(4);
        check("post_rst_oe", pad_out_en, 8'h08);
        ticks(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
